// File: rtl/obi_sbr_byte_mailbox.sv
// obi_sbr_byte_mailbox: OBI subordinate that moves PJON payload bytes between
// the CPU and two 8-bit byte streams. Each stream sits behind its own FIFO.
//
// Register window, decoded on addr[3:2]:
//   0x0 DATA   W: push wdata[7:0] to TX when be[0]; R: pop a byte from RX
//   0x4 STATUS R: [0]tx_full [1]tx_empty [2]rx_full [3]rx_empty
//                 [15:8]tx_count [23:16]rx_count
//   0x8 CTRL   [0] clear both FIFOs (write 1, reads 0), [1] irq_en
//   0xC OVF    [0] sticky RX overflow, write 1 to clear
//
// Optional feature macro: OBI_MAILBOX_IRQ_EN
//   defined   : irq_o = irq_en && (!rx_empty || rx_overflow), registered
//   undefined : irq_o tied 0 and CTRL[1] is read-only zero
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   obi_req_i         OBI request from the crossbar
//   obi_rsp_o         OBI response; gnt follows req combinationally
//   tx_data_o/valid_o TX FIFO head toward the PJON engine, tx_ready_i pops
//   rx_data_i/valid_i bytes from the PJON engine, rx_ready_o = RX not full
//   irq_o             level interrupt

package obi_sbr_byte_mailbox_pkg;

   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 32;
   localparam int unsigned IdWidth   = 4;

   typedef struct packed {
      logic [AddrWidth-1:0]   addr;
      logic                   we;
      logic [DataWidth/8-1:0] be;
      logic [DataWidth-1:0]   wdata;
      logic [IdWidth-1:0]     aid;
   } obi_a_chan_t;

   typedef struct packed {
      logic        req;
      obi_a_chan_t a;
   } obi_req_t;

   typedef struct packed {
      logic [DataWidth-1:0] rdata;
      logic [IdWidth-1:0]   rid;
      logic                 err;
   } obi_r_chan_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      obi_r_chan_t r;
   } obi_rsp_t;

endpackage

module obi_sbr_byte_mailbox #(
   parameter type         obi_req_t = obi_sbr_byte_mailbox_pkg::obi_req_t,
   parameter type         obi_rsp_t = obi_sbr_byte_mailbox_pkg::obi_rsp_t,
   parameter int unsigned FifoDepth = 8
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  obi_req_t   obi_req_i,
   output obi_rsp_t   obi_rsp_o,
   output logic [7:0] tx_data_o,
   output logic       tx_valid_o,
   input  logic       tx_ready_i,
   input  logic [7:0] rx_data_i,
   input  logic       rx_valid_i,
   output logic       rx_ready_o,
   output logic       irq_o
);

   localparam int unsigned PtrW = $clog2(FifoDepth);
   localparam int unsigned CntW = $clog2(FifoDepth) + 1;

   localparam logic [1:0] RegData   = 2'd0;
   localparam logic [1:0] RegStatus = 2'd1;
   localparam logic [1:0] RegCtrl   = 2'd2;
   localparam logic [1:0] RegOvf    = 2'd3;

   logic [7:0]      tx_mem [FifoDepth];
   logic [7:0]      rx_mem [FifoDepth];

   logic [PtrW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [PtrW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [CntW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic            ovf_q, ovf_d;
   obi_rsp_t        rsp_q, rsp_d;
   logic            irq_en_q;

   logic            tx_full, tx_empty, rx_full, rx_empty;
   logic            tx_push, tx_pop, rx_push, rx_pop, clear;
   logic [1:0]      sel;
   logic [31:0]     status;

   // Flags come from the registered counts, i.e. the state before this cycle.
   assign tx_full  = (tx_cnt_q == CntW'(FifoDepth));
   assign tx_empty = (tx_cnt_q == '0);
   assign rx_full  = (rx_cnt_q == CntW'(FifoDepth));
   assign rx_empty = (rx_cnt_q == '0);

   assign tx_valid_o = !tx_empty;
   assign tx_data_o  = tx_mem[tx_rd_q];
   assign rx_ready_o = !rx_full;

   assign sel    = obi_req_i.a.addr[3:2];
   assign status = {8'h00, 8'(rx_cnt_q), 8'(tx_cnt_q), 4'h0,
                    rx_empty, rx_full, tx_empty, tx_full};

   // Next-state: FIFO side effects happen in the grant cycle, response is registered.
   always_comb begin
      tx_push = 1'b0;
      rx_pop  = 1'b0;
      clear   = 1'b0;
      ovf_d   = ovf_q;
      rsp_d   = rsp_q;

      rsp_d.gnt    = 1'b0;
      rsp_d.rvalid = obi_req_i.req;

      if (obi_req_i.req) begin
         rsp_d.r.rid   = obi_req_i.a.aid;
         rsp_d.r.rdata = '0;
         rsp_d.r.err   = 1'b0;
         case (sel)
            RegData: begin
               if (obi_req_i.a.we) begin
                  if (obi_req_i.a.be[0]) begin
                     tx_push     = !tx_full;
                     rsp_d.r.err = tx_full;
                  end
               end else if (rx_empty) begin
                  rsp_d.r.err = 1'b1;
               end else begin
                  rx_pop        = 1'b1;
                  rsp_d.r.rdata = {24'h0, rx_mem[rx_rd_q]};
               end
            end
            RegStatus: begin
               if (!obi_req_i.a.we) rsp_d.r.rdata = status;
            end
            RegCtrl: begin
               if (obi_req_i.a.we) clear = obi_req_i.a.wdata[0];
               else                rsp_d.r.rdata = {30'h0, irq_en_q, 1'b0};
            end
            default: begin
               if (obi_req_i.a.we) begin
                  if (obi_req_i.a.wdata[0]) ovf_d = 1'b0;
               end else begin
                  rsp_d.r.rdata = {31'h0, ovf_q};
               end
            end
         endcase
      end

      // A new overflow event wins over a same-cycle software clear.
      if (rx_valid_i && rx_full) ovf_d = 1'b1;

      // Stream-side transfers are discarded by a same-cycle clear.
      tx_pop  = tx_ready_i && !tx_empty && !clear;
      rx_push = rx_valid_i && !rx_full && !clear;

      if (clear) begin
         tx_wr_d  = '0;
         tx_rd_d  = '0;
         tx_cnt_d = '0;
         rx_wr_d  = '0;
         rx_rd_d  = '0;
         rx_cnt_d = '0;
      end else begin
         tx_wr_d  = tx_push ? tx_wr_q + PtrW'(1) : tx_wr_q;
         tx_rd_d  = tx_pop  ? tx_rd_q + PtrW'(1) : tx_rd_q;
         tx_cnt_d = tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);
         rx_wr_d  = rx_push ? rx_wr_q + PtrW'(1) : rx_wr_q;
         rx_rd_d  = rx_pop  ? rx_rd_q + PtrW'(1) : rx_rd_q;
         rx_cnt_d = rx_cnt_q + CntW'(rx_push) - CntW'(rx_pop);
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         rx_cnt_q <= '0;
         ovf_q    <= 1'b0;
         rsp_q    <= '0;
      end else begin
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         rx_cnt_q <= rx_cnt_d;
         ovf_q    <= ovf_d;
         rsp_q    <= rsp_d;
      end
   end

   // FIFO storage, no reset needed: contents are qualified by the counts.
   always_ff @(posedge clk_i) begin
      if (tx_push) tx_mem[tx_wr_q] <= obi_req_i.a.wdata[7:0];
      if (rx_push) rx_mem[rx_wr_q] <= rx_data_i;
   end

   // gnt is the only combinational response field.
   always_comb begin
      obi_rsp_o     = rsp_q;
      obi_rsp_o.gnt = obi_req_i.req;
   end

`ifdef OBI_MAILBOX_IRQ_EN
   logic irq_en_d, irq_q;

   always_comb begin
      irq_en_d = irq_en_q;
      if (obi_req_i.req && obi_req_i.a.we && (sel == RegCtrl))
         irq_en_d = obi_req_i.a.wdata[1];
   end

   // Interrupt follows the registered state with one cycle of lag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_en_q && (!rx_empty || ovf_q);
      end
   end

   assign irq_o = irq_q;

   logic unused_bits;
   assign unused_bits = ^{obi_req_i.a.addr[31:4], obi_req_i.a.addr[1:0],
                          obi_req_i.a.be[3:1], obi_req_i.a.wdata[31:8]};
`else
   assign irq_en_q = 1'b0;
   assign irq_o    = 1'b0;

   logic unused_bits;
   assign unused_bits = ^{obi_req_i.a.addr[31:4], obi_req_i.a.addr[1:0],
                          obi_req_i.a.be[3:1], obi_req_i.a.wdata[31:8],
                          obi_req_i.a.wdata[1]};
`endif

endmodule
